// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and helpers for the instruction-fetch front end
package fetch_pkg;

  // addi x0, x0, 0: what decode sees on the data lines when nothing is buffered
  localparam logic [31:0] RV_NOP           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered fetch: the word and the address it was read from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: RV_NOP};

  // Instruction addresses are word aligned; low bits of a target are dropped
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - imem, redirect and decode-side signals of the fetch stage
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  // Fetch-stage side
  modport master (
    output imem_req,
    output imem_addr,
    output out_valid,
    output out_pc,
    output out_instr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  out_ready
  );

  // Environment side: instruction memory, execute and decode
  modport slave (
    input  imem_req,
    input  imem_addr,
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small fetch buffer holding {pc, instr} entries in program order
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers/occupancy; a flush wins over a push arriving in the same cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= EMPTY_ENTRY;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head is read combinationally so decode sees it the cycle it lands; NOP when empty
  always_comb begin
    head = EMPTY_ENTRY;
    if (count_q != '0) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch front end: PC, imem issue/credit, redirect and output buffer
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  resp_entry;
  logic          out_valid;
  logic          deq;
  logic          issue;
  logic          push;
  logic [CW1-1:0] credit_used;

  // Handshake and credit: a new read is allowed only if its word is sure to find a free slot
  always_comb begin
    out_valid   = (count != '0) & !bus.redirect_valid;
    deq         = out_valid & bus.out_ready;
    credit_used = CW1'(count) + CW1'(inflight_q) - CW1'(deq);
    issue       = !rst & !bus.redirect_valid & (credit_used < CW1'(FIFO_DEPTH));
    push        = inflight_q & !bus.redirect_valid;
    resp_entry  = '{pc: req_pc_q, instr: bus.imem_rdata};
  end

  // PC sequencing: a redirect replaces the PC and suppresses issue, else advance on issue
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (bus.redirect_valid) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end
  end

  // Fetch state registers; reset drops any response still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0000_0000;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (resp_entry),
    .pop       (deq),
    .flush     (bus.redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with queue model and directed vectors
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  fetch_if bus();

  fetch_stage #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: 1-cycle latency, word = A000_0000 | address
  logic [31:0] mem_addr_q = 32'h0;
  always @(posedge clk) if (bus.imem_req) mem_addr_q <= bus.imem_addr;
  assign bus.imem_rdata = 32'hA000_0000 | mem_addr_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Model: buffered PCs in a queue, one outstanding read, next fetch address, expected stream PC
  logic [31:0] mq[$];
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = 32'h0;
  logic [31:0] m_fetch = RST_PC;
  logic [31:0] m_seq = RST_PC;
  bit          e_valid, e_deq, e_req;
  logic [31:0] e_pc, e_instr;

  always @(negedge clk) begin
    if (rst) begin
      chk("m_rst_req",   bus.imem_req,  32'h0);
      chk("m_rst_valid", bus.out_valid, 32'h0);
      chk("m_rst_pc",    bus.out_pc,    32'h0);
      chk("m_rst_instr", bus.out_instr, RV_NOP);
      chk("m_rst_addr",  bus.imem_addr, RST_PC);
      mq.delete();
      m_pend  = 1'b0;
      m_fetch = RST_PC;
      m_seq   = RST_PC;
    end else begin
      e_valid = (mq.size() != 0) && !bus.redirect_valid;
      e_deq   = e_valid && bus.out_ready;
      e_pc    = (mq.size() != 0) ? mq[0] : 32'h0;
      e_instr = (mq.size() != 0) ? (32'hA000_0000 | mq[0]) : RV_NOP;
      e_req   = !bus.redirect_valid &&
                ((mq.size() + (m_pend ? 1 : 0) - (e_deq ? 1 : 0)) < DEPTH);
      chk("m_req",   bus.imem_req,  e_req);
      chk("m_addr",  bus.imem_addr, m_fetch);
      chk("m_valid", bus.out_valid, e_valid);
      chk("m_pc",    bus.out_pc,    e_pc);
      chk("m_instr", bus.out_instr, e_instr);
      if (bus.out_valid && bus.out_ready) begin
        chk("stream_pc", bus.out_pc, m_seq);
        m_seq = m_seq + 32'd4;
      end
      if (bus.redirect_valid) begin
        mq.delete();
        m_pend  = 1'b0;
        m_fetch = {bus.redirect_pc[31:2], 2'b00};
        m_seq   = m_fetch;
      end else begin
        if (e_deq) void'(mq.pop_front());
        if (m_pend) mq.push_back(m_pend_pc);
        if (e_req) begin
          m_pend    = 1'b1;
          m_pend_pc = m_fetch;
          m_fetch   = m_fetch + 32'd4;
        end else begin
          m_pend = 1'b0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  // Hold reset two cycles, release just after an edge; that cycle is cycle 0
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.out_ready = rdy;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, bus.out_valid, 32'h1);
    chk({name, "_pc"},    bus.out_pc,    pc);
    chk({name, "_instr"}, bus.out_instr, 32'hA000_0000 | pc);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b1;

    // 1: reset values, first fetch latency, back-to-back stream
    next_cycle();
    settle();
    chk("rst_valid", bus.out_valid, 32'h0);
    chk("rst_req",   bus.imem_req,  32'h0);
    chk("rst_pc",    bus.out_pc,    32'h0);
    chk("rst_instr", bus.out_instr, 32'h0000_0013);
    do_reset(1'b1);
    settle();
    chk("t1_c0_req",   bus.imem_req,  32'h1);
    chk("t1_c0_addr",  bus.imem_addr, 32'h0);
    chk("t1_c0_valid", bus.out_valid, 32'h0);
    next_cycle(); settle();
    chk("t1_c1_valid", bus.out_valid, 32'h0);
    chk("t1_c1_addr",  bus.imem_addr, 32'h4);
    next_cycle(); settle();
    expect_out("t1_c2", 32'h0);
    for (int k = 1; k <= 5; k++) begin
      next_cycle(); settle();
      expect_out("t1_seq", 32'(4 * k));
    end

    // 2: decode stalls from the first valid for 10 cycles
    do_reset(1'b1);
    next_cycle();
    next_cycle();
    bus.out_ready = 1'b0;
    settle();
    expect_out("t2_c2", 32'h0);
    chk("t2_c2_req", bus.imem_req, 32'h0);
    for (int k = 3; k <= 11; k++) begin
      next_cycle(); settle();
      chk("t2_hold_pc",  bus.out_pc,    32'h0);
      chk("t2_hold_req", bus.imem_req,  32'h0);
    end
    next_cycle();
    bus.out_ready = 1'b1;
    settle();
    expect_out("t2_rel0", 32'h0);
    next_cycle(); settle();
    expect_out("t2_rel1", 32'h4);
    next_cycle(); settle();
    expect_out("t2_rel2", 32'h8);

    // 3: redirect in cycle 5 with the buffer full
    do_reset(1'b0);
    repeat (5) next_cycle();
    redirect(32'h100);
    bus.out_ready = 1'b1;
    settle();
    chk("t3_n_valid", bus.out_valid, 32'h0);
    chk("t3_n_req",   bus.imem_req,  32'h0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    settle();
    chk("t3_n1_req",   bus.imem_req,  32'h1);
    chk("t3_n1_addr",  bus.imem_addr, 32'h100);
    chk("t3_n1_valid", bus.out_valid, 32'h0);
    next_cycle(); settle();
    chk("t3_n2_valid", bus.out_valid, 32'h0);
    next_cycle(); settle();
    expect_out("t3_n3", 32'h100);
    next_cycle(); settle();
    expect_out("t3_n4", 32'h104);

    // 4: unaligned target, then two consecutive redirects
    next_cycle();
    redirect(32'h203);
    next_cycle();
    bus.redirect_valid = 1'b0;
    next_cycle();
    next_cycle(); settle();
    expect_out("t4_align", 32'h200);
    next_cycle(); settle();
    expect_out("t4_align1", 32'h204);
    next_cycle();
    redirect(32'h40);
    next_cycle();
    redirect(32'h80);
    settle();
    chk("t4_m1_valid", bus.out_valid, 32'h0);
    next_cycle();
    bus.redirect_valid = 1'b0;
    settle();
    chk("t4_m2_valid", bus.out_valid, 32'h0);
    next_cycle(); settle();
    chk("t4_m3_valid", bus.out_valid, 32'h0);
    next_cycle(); settle();
    expect_out("t4_m4", 32'h80);
    next_cycle(); settle();
    expect_out("t4_m5", 32'h84);

    // 5: PC wraps past the top of the address space
    next_cycle();
    redirect(32'hFFFF_FFF8);
    next_cycle();
    bus.redirect_valid = 1'b0;
    next_cycle();
    next_cycle(); settle();
    expect_out("t5_w0", 32'hFFFF_FFF8);
    next_cycle(); settle();
    expect_out("t5_w1", 32'hFFFF_FFFC);
    next_cycle(); settle();
    expect_out("t5_w2", 32'h0000_0000);

    // 6: reset asserted mid-stream acts immediately and restarts cleanly
    next_cycle(); settle();
    chk("t6_pre_valid", bus.out_valid, 32'h1);
    rst = 1'b1;
    settle();
    chk("t6_rst_valid", bus.out_valid, 32'h0);
    chk("t6_rst_req",   bus.imem_req,  32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    cyc = 0;
    settle();
    chk("t6_c0_req",   bus.imem_req,  32'h1);
    chk("t6_c0_addr",  bus.imem_addr, RST_PC);
    chk("t6_c0_valid", bus.out_valid, 32'h0);
    next_cycle(); settle();
    chk("t6_c1_valid", bus.out_valid, 32'h0);
    next_cycle(); settle();
    expect_out("t6_c2", RST_PC);
    next_cycle(); settle();
    expect_out("t6_c3", RST_PC + 32'd4);
    repeat (3) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
